imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
// Loads a program into the 3-stage CPU's instruction memory from a byte stream.
// It holds the CPU in reset while loading and owns the memory address and write
// port. When the CPU is running it passes the CPU fetch address through. It sits
// between the top-level pin interface and the CPU/instruction-memory pair.
// PARAMETERS
// ADDR_W   8   instruction memory address width (depth = 2**ADDR_W words)
// INSTR_W  16  instruction width; must equal 16 (two bytes per word)
// PORTS
// clk          in   1       system clock
// reset        in   1       synchronous, active-high reset
// load_start   in   1       1-cycle pulse: begin (or restart) a load session
// byte_valid   in   1       byte_data valid this cycle
// byte_ready   out  1       loader accepts byte_data this cycle
// byte_data    in   8       stream byte
// fetch_addr   in   ADDR_W  CPU fetch PC
// mem_addr     out  ADDR_W  instruction memory address (muxed)
// mem_we       out  1       instruction memory write strobe
// mem_wdata    out  INSTR_W write data {hi_byte, lo_byte}; opcode is lo_byte
// cpu_hold     out  1       CPU reset request (ORed with system reset by top)
// load_done    out  1       sticky: last session completed, checksum OK
// load_err     out  1       sticky: last session checksum mismatch
// BEHAVIOUR
// - Reset: state=IDLE; cpu_hold=0, mem_we=0, byte_ready=0, load_done=0, load_err=0,
//   count/index/checksum=0. CPU runs the existing memory contents.
// - Byte transfer happens when byte_valid && byte_ready in the same cycle. byte_ready is
//   high only in LEN, LO, HI and CSUM. A byte presented while ready is low is not consumed.
// - FSM:
//   IDLE : load_start -> LEN.
//   LEN  : accept N (instruction count; 0 means 2**ADDR_W); index=0, csum=N -> LO.
//   LO   : accept lo byte, csum^=byte -> HI.
//   HI   : accept hi byte, csum^=byte -> WRITE.
//   WRITE: mem_we=1 for exactly 1 cycle, mem_addr=index, mem_wdata={hi,lo};
//          index+=1. If index+1 == N (mod 2**ADDR_W) -> CSUM, else -> LO.
//   CSUM : accept byte; if byte==csum then load_done=1 -> IDLE,
//          else load_err=1 -> ERR.
//   ERR  : cpu_hold stays 1. load_start -> LEN. No other exit except reset.
// - cpu_hold=1 in LEN, LO, HI, WRITE, CSUM and ERR; it is 0 only in IDLE. The CPU
//   restarts at PC 0 on the cycle after the return to IDLE.
// - load_start in any state aborts the session. The next state is LEN, with
//   load_done/load_err cleared and index/csum cleared. A byte offered in that same
//   cycle is ignored (byte_ready forced 0). Memory words already written stay written.
// - Latency: the hi byte accepted at cycle t produces mem_we at t+1, and byte_ready
//   returns at t+2.
// - Address mux: mem_addr = fetch_addr when state==IDLE; otherwise it is the load index.
//   The mux is combinational; there is no added fetch latency in IDLE.
// - Arithmetic: index is ADDR_W bits and wraps. N=0 with ADDR_W=8 writes 256 words.
//   csum is an 8-bit XOR over N and all instruction bytes.
// - Reset in mid-session returns to IDLE immediately and drops cpu_hold. A partial
//   image is left in memory.
// STRUCTURE
// - Package imem_load_pkg: state enum {IDLE,LEN,LO,HI,WRITE,CSUM,ERR} and BYTE_W=8.
// - No sub-module. Single FSM, index/count/csum registers and the address mux.
// TESTING
// - Load N=2: bytes 02, 01 05, 03 00, csum 02^01^05^03^00=05 -> writes @0=0x0501 and
//   @1=0x0003; load_done=1; cpu_hold falls 1 cycle after the csum byte.
// - Same stream with csum 0x06 -> load_err=1, cpu_hold stays 1. Next load_start + valid
//   image -> load_done=1, load_err=0.
// - byte_valid held high continuously -> exactly one byte consumed per ready cycle, no
//   byte taken in WRITE, mem_we pulses are 1 cycle wide.
// - load_start asserted during the HI byte of word 1 -> no write for that word; LEN
//   expected next; word 0 keeps its value.
// - N=0 (ADDR_W=8): 512 data bytes -> 256 writes, index wraps to 0, CSUM state entered
//   after the addr 0xFF write.
// - IDLE with fetch_addr=0x3C -> mem_addr=0x3C in the same cycle, mem_we=0, cpu_hold=0.
//   Reset mid-load -> IDLE next cycle.

Source files
------------

// File: rtl/imem_load_pkg.sv
// Shared types for the instruction-memory loader: FSM states and stream byte width.
package imem_load_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5,
    ERR   = 3'd6
  } state_e;

  // States in which the loader consumes a stream byte.
  function automatic logic takes_byte(input state_e s);
    return (s == LEN) || (s == LO) || (s == HI) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Pin-side byte stream, CPU fetch address and instruction-memory port of the loader.
interface imem_load_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);

  logic                              load_start;
  logic                              byte_valid;
  logic                              byte_ready;
  logic [imem_load_pkg::BYTE_W-1:0]  byte_data;
  logic [ADDR_W-1:0]                 fetch_addr;
  logic [ADDR_W-1:0]                 mem_addr;
  logic                              mem_we;
  logic [INSTR_W-1:0]                mem_wdata;
  logic                              cpu_hold;
  logic                              load_done;
  logic                              load_err;

  modport master (
    output load_start, byte_valid, byte_data, fetch_addr,
    input  byte_ready, mem_addr, mem_we, mem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    input  load_start, byte_valid, byte_data, fetch_addr,
    output byte_ready, mem_addr, mem_we, mem_wdata, cpu_hold, load_done, load_err
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// Loads {N, lo/hi byte pairs, xor checksum} into instruction memory while holding the
// CPU in reset; outside a session the CPU fetch address passes straight to the memory.
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  imem_load_ctrl_if.slave    bus
);

  state_e              state_r;
  state_e              state_nxt;
  logic [ADDR_W-1:0]   idx_r;
  logic [ADDR_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   idx_inc_s;
  logic [BYTE_W-1:0]   csum_r;
  logic [BYTE_W-1:0]   lo_r;
  logic [BYTE_W-1:0]   hi_r;
  logic                done_r;
  logic                err_r;
  logic                take_s;

  // A load_start in the same cycle wins over any offered byte.
  assign bus.byte_ready = takes_byte(state_r) && !bus.load_start;
  assign take_s         = bus.byte_valid && bus.byte_ready;
  assign idx_inc_s      = idx_r + ADDR_W'(1);

  assign bus.mem_addr   = (state_r == IDLE) ? bus.fetch_addr : idx_r;
  assign bus.mem_we     = (state_r == WRITE);
  assign bus.mem_wdata  = INSTR_W'({hi_r, lo_r});
  assign bus.cpu_hold   = (state_r != IDLE);
  assign bus.load_done  = done_r;
  assign bus.load_err   = err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; count N wraps so that N=0 means a full 2**ADDR_W image.
  always_comb begin
    state_nxt = state_r;
    if (bus.load_start) begin
      state_nxt = LEN;
    end else begin
      case (state_r)
        IDLE:    state_nxt = IDLE;
        LEN:     state_nxt = take_s ? LO : LEN;
        LO:      state_nxt = take_s ? HI : LO;
        HI:      state_nxt = take_s ? WRITE : HI;
        WRITE:   state_nxt = (idx_inc_s == cnt_r) ? CSUM : LO;
        CSUM: begin
          if (take_s) begin
            state_nxt = (bus.byte_data == csum_r) ? IDLE : ERR;
          end else begin
            state_nxt = CSUM;
          end
        end
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Session datapath: index, count, checksum, staged bytes and sticky result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r  <= '0;
      cnt_r  <= '0;
      csum_r <= '0;
      lo_r   <= '0;
      hi_r   <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (bus.load_start) begin
      idx_r  <= '0;
      csum_r <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state_r)
        LEN: begin
          if (take_s) begin
            cnt_r  <= ADDR_W'(bus.byte_data);
            idx_r  <= '0;
            csum_r <= bus.byte_data;
          end
        end
        LO: begin
          if (take_s) begin
            lo_r   <= bus.byte_data;
            csum_r <= csum_r ^ bus.byte_data;
          end
        end
        HI: begin
          if (take_s) begin
            hi_r   <= bus.byte_data;
            csum_r <= csum_r ^ bus.byte_data;
          end
        end
        WRITE: begin
          idx_r <= idx_inc_s;
        end
        CSUM: begin
          if (take_s) begin
            if (bus.byte_data == csum_r) begin
              done_r <= 1'b1;
            end else begin
              err_r  <= 1'b1;
            end
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench: random byte-stream images checked against the image and
// xor checksum the bench builds itself, plus abort, error, wrap and reset scenarios.
module tb_imem_load_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_load_ctrl_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  imem_load_ctrl #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_cnt   = 0;
  int          acc_cnt  = 0;
  logic [15:0] mem_model [256];
  logic [15:0] img       [256];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Instruction memory and stream observer.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.byte_valid && bus.byte_ready) acc_cnt++;
      if (bus.mem_we) begin
        mem_model[bus.mem_addr] = bus.mem_wdata;
        wr_cnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int w;
    if (gaps) begin
      bus.byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.byte_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.byte_ready) check_val("byte_timeout", {31'd0, bus.byte_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
  endtask

  // Send the first nw words of img; n==0 encodes 256 words.
  task automatic load_image(input int n, input bit corrupt, input bit gaps);
    int nw, wr0, acc0, bad;
    logic [7:0] cs;
    nw   = (n == 0) ? 256 : n;
    wr0  = wr_cnt;
    acc0 = acc_cnt;
    pulse_start();
    cs = n[7:0];
    send_byte(n[7:0], gaps);
    for (int i = 0; i < nw; i++) begin
      send_byte(img[i][7:0], gaps);
      send_byte(img[i][15:8], gaps);
      cs = cs ^ img[i][7:0] ^ img[i][15:8];
      @(negedge clk);
      check_val("we_latency", {31'd0, bus.mem_we}, 32'd1);
      check_val("we_addr", {24'd0, bus.mem_addr}, i & 32'hFF);
      check_val("ready_in_write", {31'd0, bus.byte_ready}, 32'd0);
    end
    send_byte(corrupt ? (cs ^ 8'h5A) : cs, gaps);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    check_val("load_done", {31'd0, bus.load_done}, {31'd0, !corrupt});
    check_val("load_err", {31'd0, bus.load_err}, {31'd0, corrupt});
    check_val("cpu_hold_end", {31'd0, bus.cpu_hold}, {31'd0, corrupt});
    check_val("write_count", wr_cnt - wr0, nw);
    check_val("bytes_taken", acc_cnt - acc0, 2 * nw + 2);
    bad = 0;
    for (int i = 0; i < nw; i++) if (mem_model[i] !== img[i]) bad++;
    check_val("mem_image", bad, 32'd0);
  endtask

  task automatic fill_random(input int nw);
    for (int i = 0; i < nw; i++) img[i] = 16'($urandom);
  endtask

  initial begin
    int wr0;
    logic [7:0] fa;
    reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.fetch_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check_val("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check_val("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    check_val("rst_done", {31'd0, bus.load_done}, 32'd0);
    check_val("rst_err", {31'd0, bus.load_err}, 32'd0);

    // Combinational fetch passthrough in IDLE.
    bus.fetch_addr = 8'h3C;
    #1;
    check_val("fetch_3c", {24'd0, bus.mem_addr}, 32'h3C);
    check_val("fetch_we", {31'd0, bus.mem_we}, 32'd0);
    check_val("fetch_hold", {31'd0, bus.cpu_hold}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      fa = 8'($urandom);
      bus.fetch_addr = fa;
      #1;
      check_val("fetch_rand", {24'd0, bus.mem_addr}, {24'd0, fa});
    end
    @(posedge clk); #1;

    // Directed N=2 image, then the same stream with a bad checksum, then recovery.
    img[0] = 16'h0501;
    img[1] = 16'h0003;
    load_image(2, 1'b0, 1'b0);
    load_image(2, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_val("err_hold", {31'd0, bus.cpu_hold}, 32'd1);
      check_val("err_ready", {31'd0, bus.byte_ready}, 32'd0);
    end
    load_image(2, 1'b0, 1'b1);

    // Random images; gaps=0 keeps byte_valid high throughout the session.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(n);
      load_image(n, ($urandom_range(0, 3) == 0), (r % 2 == 1));
      if (bus.load_err) load_image(n, 1'b0, 1'b0);
    end

    // Abort during the hi byte of word 1.
    fill_random(3);
    wr0 = wr_cnt;
    pulse_start();
    send_byte(8'd3, 1'b0);
    send_byte(img[0][7:0], 1'b0);
    send_byte(img[0][15:8], 1'b0);
    @(negedge clk);
    send_byte(img[1][7:0], 1'b0);
    bus.byte_data  = img[1][15:8];
    bus.load_start = 1'b1;
    @(negedge clk);
    check_val("abort_ready_forced", {31'd0, bus.byte_ready}, 32'd0);
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    check_val("abort_len_ready", {31'd0, bus.byte_ready}, 32'd1);
    check_val("abort_hold", {31'd0, bus.cpu_hold}, 32'd1);
    check_val("abort_done_clr", {31'd0, bus.load_done}, 32'd0);
    check_val("abort_no_write", wr_cnt - wr0, 32'd1);
    check_val("abort_word0", {16'd0, mem_model[0]}, {16'd0, img[0]});
    fill_random(1);
    load_image(1, 1'b0, 1'b0);

    // N=0: full 256-word image with index wrap.
    fill_random(256);
    load_image(0, 1'b0, 1'b0);

    // Reset in mid-session.
    fill_random(4);
    pulse_start();
    send_byte(8'd4, 1'b0);
    send_byte(img[0][7:0], 1'b0);
    bus.byte_valid = 1'b0;
    bus.fetch_addr = 8'hA7;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("midrst_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check_val("midrst_ready", {31'd0, bus.byte_ready}, 32'd0);
    check_val("midrst_addr", {24'd0, bus.mem_addr}, 32'hA7);
    check_val("midrst_done", {31'd0, bus.load_done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
